// File: rtl/modport_mem.sv
// Single-port word memory behind a valid/ready handshake.
// Each accepted transfer costs two cycles: IDLE (accept) then BUSY (recover).
// Reset clears every word in one edge and parks the FSM in INIT for a cycle.
module modport_mem #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic                  wt_rd,
   input  logic                  valid,
   output logic [WIDTH-1:0]      rdata,
   output logic                  ready
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_BUSY = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic             ready_q, ready_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   logic accept_c;
   logic wr_en_c;
   logic rd_en_c;

   // State register; reset forces INIT regardless of any in-flight transfer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: INIT leaves after one cycle, IDLE waits for valid, BUSY always returns.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_INIT: state_d = ST_IDLE;
         ST_IDLE: if (valid) state_d = ST_BUSY;
         ST_BUSY: state_d = ST_IDLE;
         default: state_d = ST_INIT;
      endcase
   end

   // Transfer strobes: a request counts only when sampled in IDLE.
   always_comb begin
      accept_c = 1'b0;
      wr_en_c  = 1'b0;
      rd_en_c  = 1'b0;
      if (state_q == ST_IDLE) begin
         accept_c = valid;
         wr_en_c  = valid & wt_rd;
         rd_en_c  = valid & ~wt_rd;
      end
   end

   // Datapath next values; ready tracks the next state so it is high exactly in IDLE.
   always_comb begin
      mem_d   = mem_q;
      rdata_d = rdata_q;
      ready_d = (state_d == ST_IDLE);
      if (wr_en_c) begin
         mem_d[addr] = wdata;
      end
      if (rd_en_c) begin
         rdata_d = mem_q[addr];
      end
   end

   // Datapath registers; reset wins over a write presented on the same edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ready_q <= 1'b0;
         rdata_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         ready_q <= ready_d;
         rdata_q <= rdata_d;
         mem_q   <= mem_d;
      end
   end

   assign rdata = rdata_q;
   assign ready = ready_q;

endmodule

// File: tb/tb_modport_mem.sv
// Directed table-driven bench for modport_mem plus a back-to-back handshake sequence.
module tb_modport_mem;

   logic        clk;
   logic        rst;
   logic [5:0]  addr;
   logic [15:0] wdata;
   logic        wt_rd;
   logic        valid;
   logic [15:0] rdata;
   logic        ready;

   int n_checks;
   int n_fails;

   typedef struct {
      logic        rst;
      logic        valid;
      logic        wt_rd;
      logic [5:0]  addr;
      logic [15:0] wdata;
      logic        exp_ready;
      logic [15:0] exp_rdata;
   } vec_t;

   vec_t vecs[$];

   modport_mem #(.WIDTH(16), .ADDR_WIDTH(6)) dut (
      .clk   (clk),
      .rst   (rst),
      .addr  (addr),
      .wdata (wdata),
      .wt_rd (wt_rd),
      .valid (valid),
      .rdata (rdata),
      .ready (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic v, input logic w, input logic [5:0] a,
                      input logic [15:0] d, input logic er, input logic [15:0] ed);
      vec_t t;
      t.rst = r; t.valid = v; t.wt_rd = w; t.addr = a; t.wdata = d;
      t.exp_ready = er; t.exp_rdata = ed;
      vecs.push_back(t);
   endtask

   // Present a transfer and hold it until accepted; waits = edges spent in non-IDLE.
   task automatic xfer(input logic we, input logic [5:0] a, input logic [15:0] d,
                       output int waits, output bit ok);
      bit done;
      done  = 1'b0;
      waits = 0;
      valid = 1'b1; wt_rd = we; addr = a; wdata = d;
      for (int n = 0; n < 8; n++) begin
         if (!done) begin
            if (ready) begin
               @(posedge clk); #1;
               done = 1'b1;
            end else begin
               @(posedge clk); #1;
               waits++;
            end
         end
      end
      valid = 1'b0;
      ok = done;
   endtask

   initial begin
      int  waits;
      bit  ok;
      n_checks = 0;
      n_fails  = 0;
      rst = 1'b0; valid = 1'b0; wt_rd = 1'b0; addr = '0; wdata = '0;

      // reset held 3 cycles, release, read addr 5
      add(0,0,0, 6'd0,  16'h0000, 0, 16'h0000);
      add(0,0,0, 6'd0,  16'h0000, 0, 16'h0000);
      add(0,0,0, 6'd0,  16'h0000, 0, 16'h0000);
      add(1,0,0, 6'd0,  16'h0000, 1, 16'h0000);
      add(1,1,0, 6'd5,  16'h0000, 0, 16'h0000);
      add(1,0,0, 6'd0,  16'h0000, 1, 16'h0000);
      // write 3 then read 3
      add(1,1,1, 6'd3,  16'hA5A5, 0, 16'h0000);
      add(1,0,0, 6'd0,  16'h0000, 1, 16'h0000);
      add(1,1,0, 6'd3,  16'h0000, 0, 16'hA5A5);
      add(1,0,0, 6'd0,  16'h0000, 1, 16'hA5A5);
      // boundary addresses 0 and 63
      add(1,1,1, 6'd0,  16'h1111, 0, 16'hA5A5);
      add(1,0,0, 6'd0,  16'h0000, 1, 16'hA5A5);
      add(1,1,1, 6'd63, 16'hFFFF, 0, 16'hA5A5);
      add(1,0,0, 6'd0,  16'h0000, 1, 16'hA5A5);
      add(1,1,0, 6'd0,  16'h0000, 0, 16'h1111);
      add(1,0,0, 6'd0,  16'h0000, 1, 16'h1111);
      add(1,1,0, 6'd63, 16'h0000, 0, 16'hFFFF);
      add(1,0,0, 6'd0,  16'h0000, 1, 16'hFFFF);
      // read 2 then 5 idle cycles, rdata holds
      add(1,1,1, 6'd2,  16'h2222, 0, 16'hFFFF);
      add(1,0,0, 6'd0,  16'h0000, 1, 16'hFFFF);
      add(1,1,0, 6'd2,  16'h0000, 0, 16'h2222);
      for (int i = 0; i < 5; i++) add(1,0,0, 6'd0, 16'h0000, 1, 16'h2222);
      // write 7, read 7 presented during BUSY is held and taken on next IDLE edge
      add(1,1,1, 6'd7,  16'h0007, 0, 16'h2222);
      add(1,1,0, 6'd7,  16'h0000, 1, 16'h2222);
      add(1,1,0, 6'd7,  16'h0000, 0, 16'h0007);
      // write to 8 during BUSY must be ignored
      add(1,1,1, 6'd8,  16'h1234, 1, 16'h0007);
      add(1,1,0, 6'd8,  16'h0000, 0, 16'h0000);
      add(1,0,0, 6'd0,  16'h0000, 1, 16'h0000);
      // write 10, one-cycle reset, read 10
      add(1,1,1, 6'd10, 16'hBEEF, 0, 16'h0000);
      add(1,0,0, 6'd0,  16'h0000, 1, 16'h0000);
      add(1,1,0, 6'd7,  16'h0000, 0, 16'h0007);
      add(0,0,0, 6'd0,  16'h0000, 0, 16'h0000);
      add(1,0,0, 6'd0,  16'h0000, 1, 16'h0000);
      add(1,1,0, 6'd10, 16'h0000, 0, 16'h0000);
      add(1,0,0, 6'd0,  16'h0000, 1, 16'h0000);
      // reset on an accepting write edge: write not retained
      add(0,1,1, 6'd12, 16'h5555, 0, 16'h0000);
      add(1,0,0, 6'd0,  16'h0000, 1, 16'h0000);
      add(1,1,0, 6'd12, 16'h0000, 0, 16'h0000);
      add(1,0,0, 6'd0,  16'h0000, 1, 16'h0000);
      // reset while BUSY after a write
      add(1,1,1, 6'd20, 16'hABCD, 0, 16'h0000);
      add(0,0,0, 6'd0,  16'h0000, 0, 16'h0000);
      add(1,0,0, 6'd0,  16'h0000, 1, 16'h0000);
      add(1,1,0, 6'd20, 16'h0000, 0, 16'h0000);
      add(1,0,0, 6'd0,  16'h0000, 1, 16'h0000);

      #2;
      foreach (vecs[i]) begin
         rst = vecs[i].rst; valid = vecs[i].valid; wt_rd = vecs[i].wt_rd;
         addr = vecs[i].addr; wdata = vecs[i].wdata;
         @(posedge clk); #1;
         check($sformatf("vec%0d_ready", i), 16'(ready), 16'(vecs[i].exp_ready));
         check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      end
      valid = 1'b0;

      // back-to-back: second transfer issued immediately waits out one BUSY cycle
      xfer(1'b1, 6'd40, 16'h4040, waits, ok);
      check("b2b_wr_accepted", 16'(ok), 16'd1);
      check("b2b_wr_ready_low", 16'(ready), 16'd0);
      xfer(1'b0, 6'd40, 16'h0000, waits, ok);
      check("b2b_rd_accepted", 16'(ok), 16'd1);
      check("b2b_rd_waits", 16'(waits), 16'd1);
      check("b2b_rd_ready_low", 16'(ready), 16'd0);
      check("b2b_rd_data", rdata, 16'h4040);
      @(posedge clk); #1;
      check("b2b_ready_back", 16'(ready), 16'd1);
      check("b2b_rdata_hold", rdata, 16'h4040);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/modport_mem.md
MODPORT_MEM -- requirements
Module: modport_mem

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, address width in bits; DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low (rst=0 at a posedge resets).
REQ-005 SHALL have port addr  input  ADDR_WIDTH  word address of the transfer.
REQ-006 SHALL have port wdata  input  WIDTH  write data.
REQ-007 SHALL have port wt_rd  input  1  transfer type: 1 = write, 0 = read.
REQ-008 SHALL have port valid  input  1  requester has a transfer on addr/wdata/wt_rd.
REQ-009 SHALL have port rdata  output  WIDTH  registered read data.
REQ-010 SHALL have port ready  output  1  memory can accept a transfer this cycle.

Function
REQ-011 SHALL contain DEPTH x WIDTH storage; every address 0..DEPTH-1 is valid, with no out-of-range case.
REQ-012 SHALL implement a 3-state FSM: INIT, IDLE, BUSY; ready SHALL be 1 only in IDLE (decoded from registered state, no combinational path from inputs).
REQ-013 INIT SHALL go to IDLE at the next posedge with rst=1.
REQ-014 A transfer SHALL be accepted at a posedge where state=IDLE and valid=1; addr, wdata and wt_rd SHALL be sampled at that edge.
REQ-015 On an accepted write, mem[addr] SHALL take wdata at the accepting edge; rdata SHALL be unchanged.
REQ-016 On an accepted read, rdata SHALL take mem[addr] at the accepting edge, visible the cycle after acceptance (latency 1).
REQ-017 After an acceptance, state SHALL go IDLE->BUSY; BUSY SHALL return to IDLE at the next edge unconditionally, so ready is low exactly one cycle per transfer; max throughput is one transfer per 2 cycles.
REQ-018 valid in BUSY or INIT SHALL be ignored with no memory or rdata change; the requester holds valid and fields until it sees ready=1 at an edge.
REQ-019 rdata SHALL hold its last read value until the next accepted read.
REQ-020 A read after a write to the same address SHALL return the newly written data.
REQ-021 valid=0 in IDLE SHALL keep state IDLE and change nothing.

Reset
REQ-022 At a posedge with rst=0, state SHALL be INIT, ready 0, rdata 0, and all DEPTH words cleared to 0 in that single edge.
REQ-023 Reset mid-transfer (state BUSY or at an accepting edge) SHALL abort: reset takes priority, and no write from that edge is retained.
REQ-024 After rst returns high, ready SHALL be 1 from the second posedge onward (INIT for one cycle).

Verification
REQ-025 Reset held 3 cycles, then released -> ready 0 during reset and first cycle after, 1 thereafter; a read of addr 5 returns 0.
REQ-026 Write addr 3 wdata 16'hA5A5, then read addr 3 -> rdata=16'hA5A5 one cycle after read acceptance; ready low one cycle after each acceptance.
REQ-027 Write addr 0 = 16'h1111 and addr 63 = 16'hFFFF, read both -> 16'h1111, 16'hFFFF (boundary addresses, no aliasing).
REQ-028 valid held high continuously with a write to addr 7 = 16'h0007 -> exactly one write committed, ready toggles 1,0,1; a second request presented during BUSY is taken only on the next IDLE edge.
REQ-029 Write addr 10 = 16'hBEEF, assert rst for 1 cycle, read addr 10 -> rdata=0.
REQ-030 Read addr 2 (=16'h2222), then idle 5 cycles with valid=0 -> rdata stays 16'h2222.
